onchip_mem_arbiter: RTL and testbench

- Two-master arbiter that shares the single-port 32-bit on-chip RAM (32000 words, 15-bit word address, byte enables) between two Avalon-MM requesters, e.g. CPU data master and a DMA master.
- Round-robin per transaction, one access per clock.
- Returns read data with readdatavalid, matching the RAM's 1-cycle read latency (registered address, unregistered q).
- Sits between the interconnect masters and the RAM slave port. Owns chipselect, write and clken sequencing.

---
 rtl/onchip_mem_arb_pkg.sv | 20 ++
 rtl/rr_arbiter_2.sv | 45 ++++
 rtl/onchip_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_arb_pkg.sv
// ============================================================================
// Module   : onchip_mem_arb_pkg
// Brief    : Shared sizes and types for the two-master on-chip RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package onchip_mem_arb_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int DEPTH  = 32000;

    // Identifies one of the two requesters (0 = m0, 1 = m1)
    typedef logic req_id_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_2.sv
// ============================================================================
// Module   : rr_arbiter_2
// Brief    : Two-way round-robin picker; combinational one-hot grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_2
    import onchip_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       freeze,
    output logic [1:0] grant
);

    req_id_t r_last_grant;

    always_comb begin
        grant = 2'b00;
        if (!reset && !freeze) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                // Contention goes to whoever was not served last
                2'b11:   grant = (r_last_grant == 1'b1) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (grant[0]) begin
            r_last_grant <= 1'b0;
        end else if (grant[1]) begin
            r_last_grant <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/onchip_mem_arbiter.sv
// ============================================================================
// Module   : onchip_mem_arbiter
// Brief    : Shares a single-port 1-cycle-latency RAM between two Avalon-MM masters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module onchip_mem_arbiter #(
    parameter int ADDR_W = onchip_mem_arb_pkg::ADDR_W,
    parameter int DATA_W = onchip_mem_arb_pkg::DATA_W,
    parameter int BE_W   = DATA_W / 8,
    parameter int DEPTH  = onchip_mem_arb_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    input  logic              freeze,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              err_oob,
    output logic              err_proto
);

    import onchip_mem_arb_pkg::*;

    // One extra bit so DEPTH == 2**ADDR_W still fits
    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic              w_gnt_any;
    req_id_t           w_sel;
    logic [ADDR_W-1:0] w_addr;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wdata;
    logic              w_rd;
    logic              w_wr;
    logic              w_in_range;
    logic              w_is_read;
    logic              w_rd_valid;
    logic [DATA_W-1:0] w_rd_data;

    logic              r_rd_pend;
    req_id_t           r_rd_owner;
    logic              r_rd_oob;
    logic              r_err_oob;
    logic              r_err_proto;

    assign w_req = {m1_read | m1_write, m0_read | m0_write};

    rr_arbiter_2 u_rr_arbiter_2 (
        .clk    (clk),
        .reset  (reset),
        .req    (w_req),
        .freeze (freeze),
        .grant  (w_grant)
    );

    assign w_gnt_any = |w_grant;
    assign w_sel     = w_grant[1];

    always_comb begin
        w_addr  = '0;
        w_be    = '0;
        w_wdata = '0;
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        if (w_grant[0]) begin
            w_addr  = m0_address;
            w_be    = m0_byteenable;
            w_wdata = m0_writedata;
            w_rd    = m0_read;
            w_wr    = m0_write;
        end else if (w_grant[1]) begin
            w_addr  = m1_address;
            w_be    = m1_byteenable;
            w_wdata = m1_writedata;
            w_rd    = m1_read;
            w_wr    = m1_write;
        end
    end

    assign w_in_range = ({1'b0, w_addr} < c_depth);
    // A simultaneous read+write behaves as a write and produces no read response
    assign w_is_read  = w_rd & ~w_wr;

    assign mem_address    = w_addr;
    assign mem_byteenable = w_be;
    assign mem_writedata  = w_wdata;
    assign mem_write      = w_wr;
    assign mem_chipselect = w_gnt_any & w_in_range;
    assign mem_clken      = ~reset;

    assign m0_waitrequest = ~reset & w_req[0] & ~w_grant[0];
    assign m1_waitrequest = ~reset & w_req[1] & ~w_grant[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pend   <= 1'b0;
            r_rd_owner  <= 1'b0;
            r_rd_oob    <= 1'b0;
            r_err_oob   <= 1'b0;
            r_err_proto <= 1'b0;
        end else begin
            r_rd_pend   <= w_is_read;
            r_rd_owner  <= w_sel;
            r_rd_oob    <= ~w_in_range;
            r_err_oob   <= r_err_oob | (w_gnt_any & ~w_in_range);
            r_err_proto <= r_err_proto | (w_rd & w_wr);
        end
    end

    // Gating with reset drops a response that falls due while reset is high
    assign w_rd_valid = r_rd_pend & ~reset;
    assign w_rd_data  = r_rd_oob ? '0 : mem_readdata;

    assign m0_readdatavalid = w_rd_valid & (r_rd_owner == 1'b0);
    assign m1_readdatavalid = w_rd_valid & (r_rd_owner == 1'b1);
    assign m0_readdata      = m0_readdatavalid ? w_rd_data : '0;
    assign m1_readdata      = m1_readdatavalid ? w_rd_data : '0;

    assign err_oob   = r_err_oob & ~reset;
    assign err_proto = r_err_proto & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
// ============================================================================
// Module   : tb_onchip_mem_arbiter
// Brief    : Table, random and directed checks of onchip_mem_arbiter against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onchip_mem_arbiter;

    import onchip_mem_arb_pkg::*;

    typedef struct {
        bit        rst, frz;
        bit        r0, w0;
        bit [14:0] a0;
        bit [3:0]  be0;
        bit [31:0] d0;
        bit        r1, w1;
        bit [14:0] a1;
        bit [3:0]  be1;
        bit [31:0] d1;
        bit        xw0, xw1, xcs, xv0, xv1;
        bit [31:0] xd0, xd1;
        bit        xoob, xpro;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, freeze;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [DATA_W-1:0] mem_writedata, mem_readdata;
    logic              err_oob, err_proto;

    onchip_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .freeze(freeze),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata),
        .err_oob(err_oob), .err_proto(err_proto)
    );

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] nw, input bit [3:0] be);
        bit [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // RAM slave: registered address, unregistered q
    bit   [31:0]       ram [DEPTH];
    logic [ADDR_W-1:0] ram_q_addr;
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
            ram_q_addr <= mem_address;
        end
    end
    assign mem_readdata = ram[ram_q_addr];

    // Reference model state
    bit [31:0] mref [DEPTH];
    bit        m_last, m_pv, m_po, m_oob, m_pro;
    bit [31:0] m_pd;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl [25];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (vector %0d)", nm, act, exp, n_vec);
        end
    endtask

    task automatic run_cycle(input vec_t v, input bit use_tbl);
        bit any0, any1, g0, g1, gr, rdop, wrop, inb, ev0, ev1;
        bit [14:0] ga;
        bit [3:0]  gbe;
        bit [31:0] gd;
        reset = v.rst;  freeze = v.frz;
        m0_read = v.r0; m0_write = v.w0; m0_address = v.a0; m0_byteenable = v.be0; m0_writedata = v.d0;
        m1_read = v.r1; m1_write = v.w1; m1_address = v.a1; m1_byteenable = v.be1; m1_writedata = v.d1;
        #2;
        any0 = v.r0 | v.w0;
        any1 = v.r1 | v.w1;
        if (v.rst || v.frz) begin g0 = 0; g1 = 0; end
        else if (any0 && any1) begin g0 = (m_last == 1'b1); g1 = !g0; end
        else begin g0 = any0; g1 = any1; end
        gr   = g0 | g1;
        ga   = g0 ? v.a0  : (g1 ? v.a1  : 15'd0);
        gbe  = g0 ? v.be0 : (g1 ? v.be1 : 4'd0);
        gd   = g0 ? v.d0  : (g1 ? v.d1  : 32'd0);
        rdop = g0 ? v.r0  : (g1 ? v.r1  : 1'b0);
        wrop = g0 ? v.w0  : (g1 ? v.w1  : 1'b0);
        inb  = int'(ga) < DEPTH;
        ev0  = m_pv && !v.rst && (m_po == 1'b0);
        ev1  = m_pv && !v.rst && (m_po == 1'b1);
        n_vec++;
        chk("m0_waitrequest", m0_waitrequest, !v.rst && any0 && !g0);
        chk("m1_waitrequest", m1_waitrequest, !v.rst && any1 && !g1);
        chk("mem_chipselect", mem_chipselect, gr && inb);
        chk("mem_write", mem_write, gr && wrop);
        chk("mem_address", mem_address, ga);
        chk("mem_byteenable", mem_byteenable, gbe);
        chk("mem_writedata", mem_writedata, gd);
        chk("mem_clken", mem_clken, !v.rst);
        chk("m0_readdatavalid", m0_readdatavalid, ev0);
        chk("m1_readdatavalid", m1_readdatavalid, ev1);
        chk("m0_readdata", m0_readdata, ev0 ? m_pd : 32'd0);
        chk("m1_readdata", m1_readdata, ev1 ? m_pd : 32'd0);
        chk("err_oob", err_oob, m_oob && !v.rst);
        chk("err_proto", err_proto, m_pro && !v.rst);
        if (use_tbl) begin
            chk("tbl_wait0", m0_waitrequest, v.xw0);
            chk("tbl_wait1", m1_waitrequest, v.xw1);
            chk("tbl_cs", mem_chipselect, v.xcs);
            chk("tbl_rdv0", m0_readdatavalid, v.xv0);
            chk("tbl_rdv1", m1_readdatavalid, v.xv1);
            chk("tbl_rdata0", m0_readdata, v.xd0);
            chk("tbl_rdata1", m1_readdata, v.xd1);
            chk("tbl_err_oob", err_oob, v.xoob);
            chk("tbl_err_proto", err_proto, v.xpro);
        end
        if (v.rst) begin
            m_last = 1; m_pv = 0; m_oob = 0; m_pro = 0;
        end else begin
            m_pv = gr && rdop && !wrop;
            m_po = g1;
            m_pd = inb ? mref[ga] : 32'd0;
            if (gr) begin
                m_last = g1;
                if (!inb) m_oob = 1;
                if (rdop && wrop) m_pro = 1;
                if (wrop && inb) mref[ga] = merge(mref[ga], gd, gbe);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        ram_q_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin ram[i] = 32'd0; mref[i] = 32'd0; end
        m_last = 1; m_pv = 0; m_po = 0; m_oob = 0; m_pro = 0; m_pd = 0;

        //          rst frz  r0 w0 a0       be0    d0            r1 w1 a1     be1     d1           xw0 xw1 xcs xv0 xv1 xd0           xd1          oob pro
        tbl[0]  = '{1, 0,  1, 0, 15'd3,   4'hF, 32'h0,        0, 0, 15'd0, 4'h0,  32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0};
        tbl[1]  = '{0, 0,  0, 1, 15'h10,  4'hF, 32'hDEADBEEF, 0, 0, 15'd0, 4'h0,  32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 0};
        tbl[2]  = '{0, 0,  1, 0, 15'h10,  4'hF, 32'h0,        0, 0, 15'd0, 4'h0,  32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 0};
        tbl[3]  = '{0, 0,  0, 1, 15'd5,   4'hF, 32'h55555555, 0, 0, 15'd0, 4'h0,  32'h0,        0, 0, 1, 1, 0, 32'hDEADBEEF, 32'h0,        0, 0};
        tbl[4]  = '{0, 0,  0, 0, 15'd0,   4'h0, 32'h0,        0, 1, 15'd9, 4'hF,  32'h99999999, 0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 0};
        tbl[5]  = '{0, 0,  1, 0, 15'd5,   4'hF, 32'h0,        1, 0, 15'd9, 4'hF,  32'h0,        0, 1, 1, 0, 0, 32'h0,        32'h0,        0, 0};
        tbl[6]  = '{0, 0,  1, 0, 15'd5,   4'hF, 32'h0,        1, 0, 15'd9, 4'hF,  32'h0,        1, 0, 1, 1, 0, 32'h55555555, 32'h0,        0, 0};
        tbl[7]  = '{0, 0,  1, 0, 15'd5,   4'hF, 32'h0,        1, 0, 15'd9, 4'hF,  32'h0,        0, 1, 1, 0, 1, 32'h0,        32'h99999999, 0, 0};
        tbl[8]  = '{0, 0,  1, 0, 15'd5,   4'hF, 32'h0,        1, 0, 15'd9, 4'hF,  32'h0,        1, 0, 1, 1, 0, 32'h55555555, 32'h0,        0, 0};
        tbl[9]  = '{0, 0,  0, 0, 15'd0,   4'h0, 32'h0,        0, 1, 15'd100, 4'hF, 32'hFFFFFFFF, 0, 0, 1, 0, 1, 32'h0,       32'h99999999, 0, 0};
        tbl[10] = '{0, 0,  0, 0, 15'd0,   4'h0, 32'h0,        0, 1, 15'd100, 4'h5, 32'h11223344, 0, 0, 1, 0, 0, 32'h0,       32'h0,        0, 0};
        tbl[11] = '{0, 0,  0, 0, 15'd0,   4'h0, 32'h0,        1, 0, 15'd100, 4'hF, 32'h0,        0, 0, 1, 0, 0, 32'h0,       32'h0,        0, 0};
        tbl[12] = '{0, 0,  1, 0, 15'd32000, 4'hF, 32'h0,      0, 0, 15'd0, 4'h0,  32'h0,        0, 0, 0, 0, 1, 32'h0,        32'hFF22FF44, 0, 0};
        tbl[13] = '{0, 0,  0, 0, 15'd0,   4'h0, 32'h0,        0, 0, 15'd0, 4'h0,  32'h0,        0, 0, 0, 1, 0, 32'h0,        32'h0,        1, 0};
        tbl[14] = '{0, 0,  1, 0, 15'd5,   4'hF, 32'h0,        0, 0, 15'd0, 4'h0,  32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h0,        1, 0};
        tbl[15] = '{1, 0,  0, 0, 15'd0,   4'h0, 32'h0,        0, 0, 15'd0, 4'h0,  32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0};
        tbl[16] = '{0, 0,  1, 0, 15'd5,   4'hF, 32'h0,        1, 0, 15'd9, 4'hF,  32'h0,        0, 1, 1, 0, 0, 32'h0,        32'h0,        0, 0};
        tbl[17] = '{0, 1,  1, 0, 15'd5,   4'hF, 32'h0,        1, 0, 15'd9, 4'hF,  32'h0,        1, 1, 0, 1, 0, 32'h55555555, 32'h0,        0, 0};
        tbl[18] = '{0, 1,  1, 0, 15'd5,   4'hF, 32'h0,        1, 0, 15'd9, 4'hF,  32'h0,        1, 1, 0, 0, 0, 32'h0,        32'h0,        0, 0};
        tbl[19] = '{0, 1,  1, 0, 15'd5,   4'hF, 32'h0,        1, 0, 15'd9, 4'hF,  32'h0,        1, 1, 0, 0, 0, 32'h0,        32'h0,        0, 0};
        tbl[20] = '{0, 0,  1, 0, 15'd5,   4'hF, 32'h0,        1, 0, 15'd9, 4'hF,  32'h0,        1, 0, 1, 0, 0, 32'h0,        32'h0,        0, 0};
        tbl[21] = '{0, 0,  0, 0, 15'd0,   4'h0, 32'h0,        0, 0, 15'd0, 4'h0,  32'h0,        0, 0, 0, 0, 1, 32'h0,        32'h99999999, 0, 0};
        tbl[22] = '{0, 0,  1, 1, 15'd7,   4'hF, 32'h77,       0, 0, 15'd0, 4'h0,  32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 0};
        tbl[23] = '{0, 0,  1, 0, 15'd7,   4'hF, 32'h0,        0, 0, 15'd0, 4'h0,  32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 1};
        tbl[24] = '{0, 0,  0, 0, 15'd0,   4'h0, 32'h0,        0, 0, 15'd0, 4'h0,  32'h0,        0, 0, 0, 1, 0, 32'h77,       32'h0,        0, 1};

        v = '{default: 0};
        v.rst = 1;
        run_cycle(v, 0);
        run_cycle(v, 0);

        for (int i = 0; i < 25; i++) run_cycle(tbl[i], 1);

        // Randomised traffic; addresses cluster at low words and around DEPTH
        for (int i = 0; i < 800; i++) begin
            int s0, s1;
            v = '{default: 0};
            v.rst = ($urandom_range(0, 49) == 0);
            v.frz = ($urandom_range(0, 9) == 0);
            s0 = $urandom_range(0, 9);
            s1 = $urandom_range(0, 9);
            v.r0 = (s0 >= 4 && s0 <= 6) || s0 == 9;
            v.w0 = (s0 == 7 || s0 == 8) || (s0 == 9 && $urandom_range(0, 3) == 0);
            v.r1 = (s1 >= 4 && s1 <= 6) || s1 == 9;
            v.w1 = (s1 == 7 || s1 == 8) || (s1 == 9 && $urandom_range(0, 3) == 0);
            v.a0 = ($urandom_range(0, 3) == 0) ? 15'(31998 + $urandom_range(0, 769)) : 15'($urandom_range(0, 7));
            v.a1 = ($urandom_range(0, 3) == 0) ? 15'(31998 + $urandom_range(0, 769)) : 15'($urandom_range(0, 7));
            v.be0 = 4'($urandom_range(0, 15));
            v.be1 = 4'($urandom_range(0, 15));
            v.d0 = $urandom;
            v.d1 = $urandom;
            run_cycle(v, 0);
        end

        // Reset landing on an m1 read response, then first contention after reset
        v = '{default: 0};
        v.r1 = 1; v.a1 = 15'd9; v.be1 = 4'hF;
        run_cycle(v, 0);
        v = '{default: 0};
        v.rst = 1;
        run_cycle(v, 1);
        v = '{default: 0};
        v.r0 = 1; v.a0 = 15'd5; v.be0 = 4'hF;
        v.r1 = 1; v.a1 = 15'd9; v.be1 = 4'hF;
        v.xw1 = 1; v.xcs = 1;
        run_cycle(v, 1);
        v = '{default: 0};
        run_cycle(v, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
